qam_demapper_frame_ctrl: RTL and testbench

QAM_DEMAPPER_FRAME_CTRL -- requirements
Module: qam_demapper_frame_ctrl

---
 rtl/qam_demapper_frame_ctrl_if.sv | 46 ++++
 rtl/qam_demapper_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_qam_demapper_frame_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qam_demapper_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// qam_demapper_frame_ctrl_if
//   Symbol stream bundle for the QAM demapper frame controller.
//
//   Signals
//     in_valid  : symbol strobe from the demapper (one symbol per high cycle)
//     in_data   : demapped symbol bits, DATA_W wide
//     out_ready : host accept
//     out_valid : output symbol valid
//     out_data  : FIFO head symbol (first-word-fall-through)
//
//   Handshake: an output transfer happens on every rising clock edge where
//   out_valid and out_ready are both high. out_valid never depends on
//   out_ready. out_data is stable while out_valid is high and no transfer
//   has happened. The input side has no back-pressure: a symbol presented
//   with in_valid that cannot be stored is dropped and counted.
//
//   Modports
//     master : the symbol source / host side (drives in_*, out_ready)
//     slave  : the frame controller (drives out_valid, out_data)
// ---------------------------------------------------------------------------
interface qam_demapper_frame_ctrl_if #(
  parameter int DATA_W = 6
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/qam_demapper_frame_ctrl.sv
// ---------------------------------------------------------------------------
// qam_demapper_frame_ctrl
//   Collects demapped QAM symbols into a FIFO and releases them to the host
//   one frame at a time. A frame is ready once the FIFO holds at least the
//   frame threshold; the host then drains exactly that many symbols, with a
//   one-cycle complete pulse on the last one.
//
//   Parameters
//     DATA_W    : bits per symbol
//     DEPTH     : FIFO depth, power of two, >= 4
//     CONT_MODE : 0 = symbols accepted only while receiving,
//                 1 = symbols accepted in every non-idle state
//
//   Ports
//     dclk       : clock, rising edge
//     reset      : synchronous, active-high
//     enable     : low forces IDLE and flushes the FIFO
//     frame_len  : symbols per frame (0 or > DEPTH means DEPTH)
//     bus        : symbol in / symbol out stream (slave side)
//     available  : frame ready or being read out
//     complete   : pulse on the last transfer of a frame
//     level      : FIFO occupancy, 0..DEPTH
//     drop_count : saturating count of discarded symbols
//     overflow   : sticky drop flag, cleared in IDLE
//     state_dbg  : current FSM state encoding
// ---------------------------------------------------------------------------
module qam_demapper_frame_ctrl #(
  parameter  int DATA_W    = 6,
  parameter  int DEPTH     = 16,
  parameter  int CONT_MODE = 0,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                      dclk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [AW:0]               frame_len,
  qam_demapper_frame_ctrl_if.slave  bus,
  output logic                      available,
  output logic                      complete,
  output logic [AW:0]               level,
  output logic [15:0]               drop_count,
  output logic                      overflow,
  output logic [1:0]                state_dbg
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RECEIVE = 2'd1,
    S_READY   = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       thr;
  logic [AW:0]       thr_sel;
  logic [AW:0]       frame_cnt;

  logic              fifo_full;
  logic              fifo_empty;
  logic              wr_permit;
  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic              flush;
  logic              load_thr;
  logic              load_cnt;

  // Out-of-range frame lengths fall back to a full-FIFO frame.
  assign thr_sel = ((frame_len != '0) && (frame_len <= DEPTH_V)) ? frame_len : DEPTH_V;

  assign fifo_full  = (level == DEPTH_V);
  assign fifo_empty = (level == '0);

  generate
    if (CONT_MODE != 0) begin : g_cont
      assign wr_permit = (state != S_IDLE);
    end else begin : g_frame
      assign wr_permit = (state == S_RECEIVE);
    end
  endgenerate

  // enable gates the write/drop decision so that drop_count holds while
  // the block is being forced back to IDLE.
  assign wr_en = enable & bus.in_valid & wr_permit & ~fifo_full;
  assign drop  = enable & bus.in_valid & (state != S_IDLE) & ~wr_en;
  assign flush = ~enable | (state == S_IDLE);

  assign bus.out_valid = (state == S_READOUT) & ~fifo_empty;
  // Masked when empty so the output is a clean zero after reset/flush.
  assign bus.out_data  = fifo_empty ? '0 : mem[rd_ptr];
  assign rd_en         = bus.out_valid & bus.out_ready;

  assign available = (state == S_READY) | (state == S_READOUT);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // FSM next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load_thr   = 1'b0;
    load_cnt   = 1'b0;
    complete   = 1'b0;

    case (state)
      S_IDLE: begin
        state_next = S_RECEIVE;
        load_thr   = 1'b1;
      end
      S_RECEIVE: begin
        // Registered level: a symbol written this cycle is not yet counted.
        if (level >= thr) begin
          state_next = S_READY;
        end
      end
      S_READY: begin
        if (bus.out_ready) begin
          state_next = S_READOUT;
          load_cnt   = 1'b1;
        end
      end
      S_READOUT: begin
        if (rd_en && (frame_cnt == (AW+1)'(1))) begin
          complete   = 1'b1;
          state_next = S_RECEIVE;
          load_thr   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A transfer that did happen still reports its complete pulse, but
    // enable low always wins the state decision.
    if (!enable) begin
      state_next = S_IDLE;
      load_thr   = 1'b0;
      load_cnt   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State, pointers, counters
  // -------------------------------------------------------------------------
  always_ff @(posedge dclk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      thr        <= '0;
      frame_cnt  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_next;

      if (load_thr) begin
        thr <= thr_sel;
      end

      if (load_cnt) begin
        frame_cnt <= thr;
      end else if (rd_en) begin
        frame_cnt <= frame_cnt - (AW+1)'(1);
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        // Simultaneous write and read leaves the occupancy unchanged.
        case ({wr_en, rd_en})
          2'b10:   level <= level + (AW+1)'(1);
          2'b01:   level <= level - (AW+1)'(1);
          default: level <= level;
        endcase
      end

      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      if (flush) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge dclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_qam_demapper_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qam_demapper_frame_ctrl
//   Drives one frame-mode (CONT_MODE=0) and one continuous-mode (CONT_MODE=1)
//   instance with identical stimulus and checks both against a queue-based
//   reference model every cycle, plus directed literal scenarios.
// ---------------------------------------------------------------------------
module tb_qam_demapper_frame_ctrl;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  localparam int PH_IDLE    = 0;
  localparam int PH_RECEIVE = 1;
  localparam int PH_READY   = 2;
  localparam int PH_READOUT = 3;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              enable;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic [AW:0]       frame_len;
  logic              chk_en = 1'b0;

  qam_demapper_frame_ctrl_if #(.DATA_W(DATA_W)) bus0 ();
  qam_demapper_frame_ctrl_if #(.DATA_W(DATA_W)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_data   = in_data;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_data   = in_data;
  assign bus1.out_ready = out_ready;

  logic [1:0]        d_valid;
  logic [1:0]        d_avail;
  logic [1:0]        d_comp;
  logic [1:0]        d_ovf;
  logic [DATA_W-1:0] d_data [2];
  logic [AW:0]       d_lvl  [2];
  logic [15:0]       d_dc   [2];
  logic [1:0]        d_st   [2];

  assign d_valid[0] = bus0.out_valid;
  assign d_valid[1] = bus1.out_valid;
  assign d_data[0]  = bus0.out_data;
  assign d_data[1]  = bus1.out_data;

  qam_demapper_frame_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CONT_MODE(0)) dut0 (
    .dclk       (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_len  (frame_len),
    .bus        (bus0),
    .available  (d_avail[0]),
    .complete   (d_comp[0]),
    .level      (d_lvl[0]),
    .drop_count (d_dc[0]),
    .overflow   (d_ovf[0]),
    .state_dbg  (d_st[0])
  );

  qam_demapper_frame_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CONT_MODE(1)) dut1 (
    .dclk       (clk),
    .reset      (reset),
    .enable     (enable),
    .frame_len  (frame_len),
    .bus        (bus1),
    .available  (d_avail[1]),
    .complete   (d_comp[1]),
    .level      (d_lvl[1]),
    .drop_count (d_dc[1]),
    .overflow   (d_ovf[1]),
    .state_dbg  (d_st[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input int k, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d) @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 models frame mode, index 1 continuous mode.
  logic [DATA_W-1:0] exp_q [2][$];
  int                m_phase [2];
  int                m_thr   [2];
  int                m_rem   [2];
  int                m_drop  [2];
  bit                m_ovf   [2];

  function automatic int thr_of(input int fl);
    return (fl >= 1 && fl <= DEPTH) ? fl : DEPTH;
  endfunction

  task automatic model_step(input int k);
    int  sz;
    bit  permit;
    bit  xfer;
    bit  wr;
    bit  drp;
    sz     = exp_q[k].size();
    permit = (k == 1) ? (m_phase[k] != PH_IDLE) : (m_phase[k] == PH_RECEIVE);
    xfer   = (m_phase[k] == PH_READOUT) && (sz > 0) && out_ready;
    wr     = enable && in_valid && permit && (sz < DEPTH);
    drp    = enable && in_valid && (m_phase[k] != PH_IDLE) && !wr;
    if (reset) begin
      exp_q[k].delete();
      m_phase[k] = PH_IDLE;
      m_thr[k]   = 0;
      m_rem[k]   = 0;
      m_drop[k]  = 0;
      m_ovf[k]   = 1'b0;
      return;
    end
    if (!enable) begin
      exp_q[k].delete();
      m_phase[k] = PH_IDLE;
      m_ovf[k]   = 1'b0;
      return;
    end
    if (xfer) void'(exp_q[k].pop_front());
    if (wr) exp_q[k].push_back(in_data);
    if (drp) begin
      if (m_drop[k] < 65535) m_drop[k]++;
      m_ovf[k] = 1'b1;
    end
    case (m_phase[k])
      PH_IDLE: begin
        m_ovf[k]   = 1'b0;
        m_phase[k] = PH_RECEIVE;
        m_thr[k]   = thr_of(int'(frame_len));
      end
      PH_RECEIVE: if (sz >= m_thr[k]) m_phase[k] = PH_READY;
      PH_READY: if (out_ready) begin
        m_phase[k] = PH_READOUT;
        m_rem[k]   = m_thr[k];
      end
      default: if (xfer) begin
        if (m_rem[k] == 1) begin
          m_phase[k] = PH_RECEIVE;
          m_thr[k]   = thr_of(int'(frame_len));
        end
        m_rem[k]--;
      end
    endcase
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- compare process + output monitor ----------------
  logic [DATA_W-1:0] got [2][$];
  int                comp_cnt  [2];
  logic [DATA_W-1:0] comp_data [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        bit e_valid;
        sz      = exp_q[k].size();
        e_valid = (m_phase[k] == PH_READOUT) && (sz > 0);
        check(k, "out_valid", 32'(d_valid[k]), 32'(e_valid));
        if (e_valid) check(k, "out_data", 32'(d_data[k]), 32'(exp_q[k][0]));
        check(k, "available", 32'(d_avail[k]),
              32'((m_phase[k] == PH_READY) || (m_phase[k] == PH_READOUT)));
        check(k, "complete", 32'(d_comp[k]), 32'(e_valid && out_ready && (m_rem[k] == 1)));
        check(k, "level", 32'(d_lvl[k]), 32'(sz));
        check(k, "drop_count", 32'(d_dc[k]), 32'(m_drop[k]));
        check(k, "overflow", 32'(d_ovf[k]), 32'(m_ovf[k]));
        if (d_valid[k] && out_ready) got[k].push_back(d_data[k]);
        if (d_comp[k]) begin
          comp_cnt[k]++;
          comp_data[k] = d_data[k];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      got[k].delete();
      comp_cnt[k] = 0;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_sym(input int v);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_avail(input int k, input string name);
    int n = 0;
    while (!d_avail[k] && n < 30) begin
      tick();
      n++;
    end
    check(k, name, 32'(d_avail[k]), 32'd1);
  endtask

  task automatic wait_comp(input int k, input string name);
    int n = 0;
    while (comp_cnt[k] == 0 && n < 100) begin
      tick();
      n++;
    end
    check(k, name, 32'(comp_cnt[k] != 0), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq;
    reset     = 1'b1;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    frame_len = 5'd4;
    tick();
    chk_en = 1'b1;
    tick();

    // reset values
    for (int k = 0; k < 2; k++) begin
      check(k, "rst_level", 32'(d_lvl[k]), 32'd0);
      check(k, "rst_drop", 32'(d_dc[k]), 32'd0);
      check(k, "rst_ovf", 32'(d_ovf[k]), 32'd0);
      check(k, "rst_valid", 32'(d_valid[k]), 32'd0);
      check(k, "rst_avail", 32'(d_avail[k]), 32'd0);
      check(k, "rst_comp", 32'(d_comp[k]), 32'd0);
      check(k, "rst_data", 32'(d_data[k]), 32'd0);
    end

    // basic frame of four symbols
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    clear_mon();
    for (int i = 1; i <= 4; i++) write_sym(i);
    wait_avail(0, "f4_avail");
    out_ready = 1'b1;
    wait_comp(0, "f4_complete");
    out_ready = 1'b0;
    check(0, "f4_count", 32'(got[0].size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (got[0].size() > i) check(0, "f4_order", 32'(got[0][i]), 32'(i + 1));
    check(0, "f4_comp_data", 32'(comp_data[0]), 32'h04);
    check(0, "f4_comp_once", 32'(comp_cnt[0]), 32'd1);
    check(0, "f4_back_rx", 32'(d_avail[0]), 32'd0);

    // writes during READY: dropped in frame mode, stored in continuous mode
    clear_mon();
    for (int i = 0; i < 4; i++) write_sym(10 + i);
    wait_avail(0, "rdy_avail");
    for (int i = 0; i < 3; i++) write_sym(20 + i);
    check(0, "rdy_drops", 32'(d_dc[0]), 32'd3);
    check(1, "rdy_drops", 32'(d_dc[1]), 32'd0);
    check(1, "rdy_level", 32'(d_lvl[1]), 32'd7);
    out_ready = 1'b1;
    wait_comp(0, "rdy_comp");
    wait_comp(1, "rdy_comp");
    out_ready = 1'b0;
    tick();
    check(0, "rdy_left", 32'(d_lvl[0]), 32'd0);
    check(1, "rdy_left", 32'(d_lvl[1]), 32'd3);
    if (got[1].size() > 0) check(1, "rdy_head", 32'(got[1][0]), 32'd10);

    // frame_len=0 -> 16; 20 writes
    do_reset();
    frame_len = 5'd0;
    tick();
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check(k, "full_level", 32'(d_lvl[k]), 32'd16);
      check(k, "full_drops", 32'(d_dc[k]), 32'd4);
      check(k, "full_ovf", 32'(d_ovf[k]), 32'd1);
    end

    // simultaneous write/read at level 5, order across wrap (continuous)
    do_reset();
    frame_len = 5'd5;
    tick();
    tick();
    clear_mon();
    for (int i = 0; i < 5; i++) write_sym(i);
    wait_avail(1, "sim_avail");
    out_ready = 1'b1;
    tick();
    check(1, "sim_pre_level", 32'(d_lvl[1]), 32'd5);
    write_sym(5);
    check(1, "sim_level", 32'(d_lvl[1]), 32'd5);
    seq = 6;
    for (int n = 0; n < 400 && got[1].size() < 40; n++) begin
      if (seq < 40 && d_lvl[1] < (AW+1)'(DEPTH)) begin
        in_valid = 1'b1;
        in_data  = DATA_W'(seq);
        seq++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check(1, "wrap_count", 32'(got[1].size()), 32'd40);
    begin
      int bad = -1;
      for (int i = 0; i < got[1].size(); i++)
        if (bad < 0 && got[1][i] != DATA_W'(i)) bad = i;
      check(1, "wrap_order_first_bad", 32'(bad), 32'hFFFF_FFFF);
    end

    // reset in READOUT with six symbols held
    do_reset();
    frame_len = 5'd6;
    tick();
    tick();
    for (int i = 0; i < 6; i++) write_sym(30 + i);
    wait_avail(0, "rst6_avail");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check(0, "rst6_level", 32'(d_lvl[0]), 32'd6);
    check(0, "rst6_valid", 32'(d_valid[0]), 32'd1);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check(k, "rst6_lvl0", 32'(d_lvl[k]), 32'd0);
      check(k, "rst6_valid0", 32'(d_valid[k]), 32'd0);
      check(k, "rst6_avail0", 32'(d_avail[k]), 32'd0);
      check(k, "rst6_comp0", 32'(d_comp[k]), 32'd0);
      check(k, "rst6_data0", 32'(d_data[k]), 32'd0);
      check(k, "rst6_drop0", 32'(d_dc[k]), 32'd0);
    end
    reset     = 1'b0;
    out_ready = 1'b0;

    // randomized traffic
    do_reset();
    enable = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_data   = DATA_W'($urandom_range(0, 63));
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5) frame_len = (AW+1)'($urandom_range(0, 20));
      enable    = ($urandom_range(0, 99) >= 2);
      tick();
    end
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // drop counter saturation, then enable cycle
    do_reset();
    frame_len = 5'd4;
    tick();
    tick();
    for (int i = 0; i < 4; i++) write_sym(i);
    wait_avail(0, "sat_avail");
    in_valid = 1'b1;
    repeat (65550) tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check(k, "sat_drop", 32'(d_dc[k]), 32'hFFFF);
      check(k, "sat_ovf", 32'(d_ovf[k]), 32'd1);
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check(k, "en_ovf_clr", 32'(d_ovf[k]), 32'd0);
      check(k, "en_drop_hold", 32'(d_dc[k]), 32'hFFFF);
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
